// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg
// Shared constants for the two-port SDRAM arbiter: FSM state encoding,
// port-owner encoding and the read data returned on an aborted access.
// No ports.
package sdram_arbiter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

   localparam logic [31:0] ABORT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/sdram_arb_rr.sv
// sdram_arb_rr
// Two-way request picker with a last-served pointer.
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_req_a/i_req_b port requests
//   i_grant         a grant is taken this cycle; pointer records o_owner
//   o_owner         selected port (OWNER_A / OWNER_B), combinational
// FIXED_PRIO=1 makes port A win every tie; otherwise ties alternate.
module sdram_arb_rr
   import sdram_arbiter_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_req_a,
   input  logic i_req_b,
   input  logic i_grant,
   output logic o_owner
);

   logic r_last;

   always_comb begin
      if (i_req_a && i_req_b)
         o_owner = (FIXED_PRIO != 0) ? OWNER_A : ~r_last;
      else
         o_owner = i_req_a ? OWNER_A : OWNER_B;
   end

   // Pointer starts at B so that A wins the first tie after reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_last <= OWNER_B;
      else if (i_grant)
         r_last <= o_owner;
   end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Arbitrates two word-access ports (A, B) onto one SDRAM controller port.
// IDLE -> BUSY on grant (owner request registered onto m_*), BUSY -> ACK on
// m_compl (m_rdata registered into owner rdata), ACK pulses the owner ack.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   a_*/b_* (cs, addr, wdata, wr_en, bytesel in; rdata, ack out)  ports
//   m_* (cs, addr, wdata, wr_en, bytesel out; rdata, compl in)    controller
//   m_config_done              controller ready; no grant before it
//   timeout_err                sticky abort flag
// Optional feature: define SDRAM_ARB_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT cycles without m_compl (owner gets ABORT_DATA, timeout_err sets).
module sdram_arbiter
   import sdram_arbiter_pkg::*;
#(
   parameter int FIXED_PRIO = 0,
   parameter int TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_cs,
   input  logic [31:2] a_addr,
   input  logic [31:0] a_wdata,
   input  logic        a_wr_en,
   input  logic [3:0]  a_bytesel,
   output logic [31:0] a_rdata,
   output logic        a_ack,
   input  logic        b_cs,
   input  logic [31:2] b_addr,
   input  logic [31:0] b_wdata,
   input  logic        b_wr_en,
   input  logic [3:0]  b_bytesel,
   output logic [31:0] b_rdata,
   output logic        b_ack,
   output logic        m_cs,
   output logic [31:2] m_addr,
   output logic [31:0] m_wdata,
   output logic        m_wr_en,
   output logic [3:0]  m_bytesel,
   input  logic [31:0] m_rdata,
   input  logic        m_compl,
   input  logic        m_config_done,
   output logic        timeout_err
);

   logic [1:0]  r_state;
   logic        r_owner;
   logic        r_m_cs;
   logic [31:2] r_m_addr;
   logic [31:0] r_m_wdata;
   logic        r_m_wr_en;
   logic [3:0]  r_m_bytesel;
   logic [31:0] r_a_rdata;
   logic [31:0] r_b_rdata;
   logic        r_a_ack;
   logic        r_b_ack;

   logic        w_grant;
   logic        w_owner;
   logic        w_done;
   logic [31:0] w_rdata;

   assign w_grant = (r_state == ST_IDLE) && m_config_done && (a_cs || b_cs);

   sdram_arb_rr #(.FIXED_PRIO(FIXED_PRIO)) u_rr (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_req_a (a_cs),
      .i_req_b (b_cs),
      .i_grant (w_grant),
      .o_owner (w_owner)
   );

`ifdef SDRAM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;

   logic [CW-1:0] r_busy_cnt;
   logic          r_timeout_err;
   logic          w_expired;

   // Counter holds the number of BUSY edges already seen without m_compl;
   // the TIMEOUT-th such edge aborts the access.
   assign w_expired = (r_state == ST_BUSY) && !m_compl &&
                      (r_busy_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else if (r_state != ST_BUSY) begin
         r_busy_cnt <= '0;
      end else if (!m_compl) begin
         r_busy_cnt <= r_busy_cnt + 1'b1;
         if (w_expired)
            r_timeout_err <= 1'b1;
      end
   end

   assign w_done      = m_compl || w_expired;
   assign w_rdata     = m_compl ? m_rdata : ABORT_DATA;
   assign timeout_err = r_timeout_err;
`else
   // TIMEOUT only sizes the abort counter, which this build omits.
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT != 0);

   assign w_done      = m_compl;
   assign w_rdata     = m_rdata;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_owner     <= OWNER_A;
         r_m_cs      <= 1'b0;
         r_m_addr    <= '0;
         r_m_wdata   <= '0;
         r_m_wr_en   <= 1'b0;
         r_m_bytesel <= '0;
         r_a_rdata   <= '0;
         r_b_rdata   <= '0;
         r_a_ack     <= 1'b0;
         r_b_ack     <= 1'b0;
      end else begin
         // Acks are raised only on entry to ACK, so they last one cycle.
         r_a_ack <= 1'b0;
         r_b_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_owner <= w_owner;
                  r_m_cs  <= 1'b1;
                  r_state <= ST_BUSY;
                  if (w_owner == OWNER_A) begin
                     r_m_addr    <= a_addr;
                     r_m_wdata   <= a_wdata;
                     r_m_wr_en   <= a_wr_en;
                     r_m_bytesel <= a_bytesel;
                  end else begin
                     r_m_addr    <= b_addr;
                     r_m_wdata   <= b_wdata;
                     r_m_wr_en   <= b_wr_en;
                     r_m_bytesel <= b_bytesel;
                  end
               end
            end
            ST_BUSY: begin
               if (w_done) begin
                  r_m_cs  <= 1'b0;
                  r_state <= ST_ACK;
                  if (r_owner == OWNER_A) begin
                     r_a_rdata <= w_rdata;
                     r_a_ack   <= 1'b1;
                  end else begin
                     r_b_rdata <= w_rdata;
                     r_b_ack   <= 1'b1;
                  end
               end
            end
            ST_ACK: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_cs      = r_m_cs;
   assign m_addr    = r_m_addr;
   assign m_wdata   = r_m_wdata;
   assign m_wr_en   = r_m_wr_en;
   assign m_bytesel = r_m_bytesel;
   assign a_rdata   = r_a_rdata;
   assign b_rdata   = r_b_rdata;
   assign a_ack     = r_a_ack;
   assign b_ack     = r_b_ack;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Self-checking bench for sdram_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the arbitration rules.
module tb_sdram_arbiter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_cs, b_cs;
   logic [31:2] a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic        a_wr_en, b_wr_en;
   logic [3:0]  a_bytesel, b_bytesel;
   logic [31:0] a_rdata, b_rdata;
   logic        a_ack, b_ack;
   logic        m_cs;
   logic [31:2] m_addr;
   logic [31:0] m_wdata;
   logic        m_wr_en;
   logic [3:0]  m_bytesel;
   logic [31:0] m_rdata;
   logic        m_compl, m_config_done, timeout_err;

   // fixed-priority instance shares all inputs
   logic [31:0] f_a_rdata, f_b_rdata;
   logic        f_a_ack, f_b_ack, f_m_cs, f_m_wr_en, f_timeout_err;
   logic [31:2] f_m_addr;
   logic [31:0] f_m_wdata;
   logic [3:0]  f_m_bytesel;

   always #5 clk = ~clk;

   sdram_arbiter #(.FIXED_PRIO(0), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .a_cs(a_cs), .a_addr(a_addr), .a_wdata(a_wdata), .a_wr_en(a_wr_en),
      .a_bytesel(a_bytesel), .a_rdata(a_rdata), .a_ack(a_ack),
      .b_cs(b_cs), .b_addr(b_addr), .b_wdata(b_wdata), .b_wr_en(b_wr_en),
      .b_bytesel(b_bytesel), .b_rdata(b_rdata), .b_ack(b_ack),
      .m_cs(m_cs), .m_addr(m_addr), .m_wdata(m_wdata), .m_wr_en(m_wr_en),
      .m_bytesel(m_bytesel), .m_rdata(m_rdata), .m_compl(m_compl),
      .m_config_done(m_config_done), .timeout_err(timeout_err)
   );

   sdram_arbiter #(.FIXED_PRIO(1), .TIMEOUT(TO)) dut_fix (
      .clk(clk), .reset(reset),
      .a_cs(a_cs), .a_addr(a_addr), .a_wdata(a_wdata), .a_wr_en(a_wr_en),
      .a_bytesel(a_bytesel), .a_rdata(f_a_rdata), .a_ack(f_a_ack),
      .b_cs(b_cs), .b_addr(b_addr), .b_wdata(b_wdata), .b_wr_en(b_wr_en),
      .b_bytesel(b_bytesel), .b_rdata(f_b_rdata), .b_ack(f_b_ack),
      .m_cs(f_m_cs), .m_addr(f_m_addr), .m_wdata(f_m_wdata), .m_wr_en(f_m_wr_en),
      .m_bytesel(f_m_bytesel), .m_rdata(m_rdata), .m_compl(m_compl),
      .m_config_done(m_config_done), .timeout_err(f_timeout_err)
   );

   typedef struct packed {
      logic        m_cs;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic        wr;
      logic [3:0]  bs;
      logic [31:0] a_rd;
      logic [31:0] b_rd;
      logic        a_ack;
      logic        b_ack;
   } outs_t;

   int total = 0;
   int bad   = 0;

   outs_t exp_o, nxt_o;
   logic  md_busy, md_ack, md_owner, md_last;

   int          ncyc = 0;
   int          ctl_wait, ctl_delay;
   logic        ctl_done, prev_mcs;
   logic [31:0] ctl_data;
   logic        rnd, hold_a, hold_b, chk_on;

   int          g, n, nm, nf, ack_cnt, na, nb;
   logic [3:0]  seq_m, seq_f;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%08h required=%08h", name, act, req);
      end
   endtask

   task automatic model_clear();
      md_busy  = 1'b0;
      md_ack   = 1'b0;
      md_owner = 1'b0;
      md_last  = 1'b1;
      exp_o    = '0;
      nxt_o    = '0;
   endtask

   // What the outputs must be after the coming clock edge, given the inputs
   // now presented and where the current transaction stands.
   task automatic predict();
      if (reset) begin
         model_clear();
         return;
      end
      nxt_o       = exp_o;
      nxt_o.a_ack = 1'b0;
      nxt_o.b_ack = 1'b0;
      if (md_ack) begin
         md_ack = 1'b0;
      end else if (md_busy) begin
         if (m_compl) begin
            md_busy     = 1'b0;
            md_ack      = 1'b1;
            nxt_o.m_cs  = 1'b0;
            if (!md_owner) begin
               nxt_o.a_rd  = m_rdata;
               nxt_o.a_ack = 1'b1;
            end else begin
               nxt_o.b_rd  = m_rdata;
               nxt_o.b_ack = 1'b1;
            end
         end
      end else if (m_config_done && (a_cs || b_cs)) begin
         md_owner   = (a_cs && b_cs) ? !md_last : b_cs;
         md_last    = md_owner;
         md_busy    = 1'b1;
         nxt_o.m_cs = 1'b1;
         if (!md_owner) begin
            nxt_o.addr = a_addr; nxt_o.wdata = a_wdata; nxt_o.wr = a_wr_en; nxt_o.bs = a_bytesel;
         end else begin
            nxt_o.addr = b_addr; nxt_o.wdata = b_wdata; nxt_o.wr = b_wr_en; nxt_o.bs = b_bytesel;
         end
      end
   endtask

   // Controller responder plus port masters, run just after each edge.
   task automatic auto_drive();
      m_compl = 1'b0;
      if (rnd) begin
         m_rdata       = $urandom();
         m_config_done = ($urandom_range(0, 9) != 0);
      end
      if (m_cs && !prev_mcs) begin
         if (rnd) ctl_delay = $urandom_range(1, 6);
         ctl_wait = ctl_delay - 1;
         ctl_done = 1'b0;
      end
      if (m_cs && !ctl_done && ctl_delay != 0) begin
         if (ctl_wait == 0) begin
            m_compl  = 1'b1;
            m_rdata  = rnd ? $urandom() : ctl_data;
            ctl_done = 1'b1;
         end else begin
            ctl_wait--;
         end
      end else if (rnd && !m_cs && $urandom_range(0, 7) == 0) begin
         m_compl = 1'b1;
      end
      prev_mcs = m_cs;

      if (a_ack) a_cs = hold_a;
      if (b_ack) b_cs = hold_b;
      if (rnd) begin
         if (!a_cs && $urandom_range(0, 2) == 0) begin
            a_cs = 1'b1; a_addr = 30'($urandom()); a_wdata = $urandom();
            a_wr_en = 1'($urandom()); a_bytesel = 4'($urandom());
         end else if (a_cs && $urandom_range(0, 4) == 0) begin
            a_addr = 30'($urandom());
         end
         if (!b_cs && $urandom_range(0, 2) == 0) begin
            b_cs = 1'b1; b_addr = 30'($urandom()); b_wdata = $urandom();
            b_wr_en = 1'($urandom()); b_bytesel = 4'($urandom());
         end else if (b_cs && $urandom_range(0, 4) == 0) begin
            b_wdata = $urandom();
         end
      end
   endtask

   task automatic cycle();
      predict();
      @(posedge clk);
      #1;
      ncyc++;
      exp_o = nxt_o;
      auto_drive();
   endtask

   always @(negedge clk) begin
      if (chk_on && !reset) begin
         chk("m_cs", 32'(m_cs), 32'(exp_o.m_cs));
         chk("a_ack", 32'(a_ack), 32'(exp_o.a_ack));
         chk("b_ack", 32'(b_ack), 32'(exp_o.b_ack));
         chk("a_rdata", a_rdata, exp_o.a_rd);
         chk("b_rdata", b_rdata, exp_o.b_rd);
         chk("ack_excl", 32'(a_ack & b_ack), 32'd0);
         chk("timeout_err", 32'(timeout_err), 32'd0);
         if (exp_o.m_cs) begin
            chk("m_addr", 32'(m_addr), 32'(exp_o.addr));
            chk("m_wdata", m_wdata, exp_o.wdata);
            chk("m_wr_en", 32'(m_wr_en), 32'(exp_o.wr));
            chk("m_bytesel", 32'(m_bytesel), 32'(exp_o.bs));
         end
      end
   end

   initial begin
      reset = 1'b1; chk_on = 1'b0; rnd = 1'b0; hold_a = 1'b0; hold_b = 1'b0;
      a_cs = 0; a_addr = '0; a_wdata = '0; a_wr_en = 0; a_bytesel = '0;
      b_cs = 0; b_addr = '0; b_wdata = '0; b_wr_en = 0; b_bytesel = '0;
      m_rdata = '0; m_compl = 0; m_config_done = 0;
      ctl_delay = 1; ctl_wait = 0; ctl_done = 1'b1; prev_mcs = 1'b0; ctl_data = '0;
      model_clear();
      repeat (3) cycle();

      // reset state
      chk("rst_m_cs", 32'(m_cs), 0);
      chk("rst_m_addr", 32'(m_addr), 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_m_wr_en", 32'(m_wr_en), 0);
      chk("rst_m_bytesel", 32'(m_bytesel), 0);
      chk("rst_a_rdata", a_rdata, 0);
      chk("rst_b_rdata", b_rdata, 0);
      chk("rst_a_ack", 32'(a_ack), 0);
      chk("rst_b_ack", 32'(b_ack), 0);
      chk("rst_timeout_err", 32'(timeout_err), 0);
      reset = 1'b0; chk_on = 1'b1;

      // no grant before controller is configured; then A read of 0x100
      a_cs = 1; a_addr = 30'h40; a_wdata = 32'h0; a_wr_en = 0; a_bytesel = 4'hF;
      ctl_delay = 6; ctl_data = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("cfg_gate_m_cs", 32'(m_cs), 0);
      end
      m_config_done = 1;
      cycle();
      g = ncyc;
      chk("cfg_grant_m_cs", 32'(m_cs), 1);
      chk("cfg_grant_addr", 32'(m_addr), 32'h40);
      n = 0;
      while (!a_ack && n < 20) begin cycle(); n++; end
      chk("rd_ack_seen", 32'(a_ack), 1);
      chk("rd_latency", 32'(ncyc - g), 6);
      chk("rd_data", a_rdata, 32'hDEADBEEF);
      cycle();
      chk("rd_ack_len", 32'(a_ack), 0);

      // both ports requesting continuously: RR gives A,B,A,B; fixed gives A,A,A,A
      reset = 1'b1; model_clear(); cycle(); reset = 1'b0;
      a_cs = 1; b_cs = 1; a_addr = 30'h111; b_addr = 30'h222;
      hold_a = 1; hold_b = 1; ctl_delay = 2; ctl_data = 32'h0BADF00D;
      seq_m = '0; seq_f = '1; nm = 0; nf = 0; n = 0;
      while ((nm < 4 || nf < 4) && n < 80) begin
         cycle(); n++;
         if (a_ack || b_ack) begin if (nm < 4) seq_m[nm] = b_ack; nm++; end
         if (f_a_ack || f_b_ack) begin if (nf < 4) seq_f[nf] = f_b_ack; nf++; end
      end
      hold_a = 0; hold_b = 0; a_cs = 0; b_cs = 0;
      chk("rr_ack_count", 32'(nm), 4);
      chk("rr_order", 32'(seq_m), 32'hA);
      chk("fixed_order", 32'(seq_f), 32'h0);
      cycle();

      // B write, address changed mid-BUSY
      b_cs = 1; b_addr = 30'h0ABCDE; b_wdata = 32'h12345678; b_wr_en = 1; b_bytesel = 4'b0011;
      ctl_delay = 5; ctl_data = 32'hCAFE0042;
      n = 0;
      while (!m_cs && n < 10) begin cycle(); n++; end
      chk("wr_grant", 32'(m_cs), 1);
      cycle(); cycle();
      b_addr = 30'h3FFFFFFF; b_wdata = 32'h0; b_bytesel = 4'hC;
      n = 0;
      while (!b_ack && n < 20) begin
         cycle(); n++;
         if (!b_ack) chk("wr_hold_addr", 32'(m_addr), 32'h0ABCDE);
      end
      chk("wr_ack_seen", 32'(b_ack), 1);
      chk("wr_wdata", m_wdata, 32'h12345678);
      chk("wr_bytesel", 32'(m_bytesel), 32'h3);
      chk("wr_wr_en", 32'(m_wr_en), 1);
      chk("wr_a_rdata_kept", a_rdata, 32'h0BADF00D);
      chk("wr_b_rdata", b_rdata, 32'hCAFE0042);
      cycle();

      // reset two cycles into BUSY
      a_cs = 1; a_addr = 30'h55; a_wdata = 32'h77; a_wr_en = 1; a_bytesel = 4'h5; ctl_delay = 6;
      n = 0;
      while (!m_cs && n < 10) begin cycle(); n++; end
      cycle(); cycle();
      chk("pre_rst_m_cs", 32'(m_cs), 1);
      reset = 1'b1; model_clear(); a_cs = 0;
      #1;
      chk("mid_rst_m_cs", 32'(m_cs), 0);
      chk("mid_rst_m_addr", 32'(m_addr), 0);
      chk("mid_rst_m_wdata", m_wdata, 0);
      chk("mid_rst_m_wr_en", 32'(m_wr_en), 0);
      chk("mid_rst_m_bytesel", 32'(m_bytesel), 0);
      chk("mid_rst_a_rdata", a_rdata, 0);
      chk("mid_rst_b_rdata", b_rdata, 0);
      ack_cnt = 0;
      for (int i = 0; i < 3; i++) begin cycle(); if (a_ack || b_ack) ack_cnt++; end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin cycle(); if (a_ack || b_ack) ack_cnt++; end
      chk("mid_rst_no_ack", 32'(ack_cnt), 0);

`ifdef SDRAM_ARB_TIMEOUT_EN
      // controller never completes: abort after TO cycles
      chk_on = 0;
      a_cs = 1; a_addr = 30'h99; ctl_delay = 0;
      n = 0;
      while (!m_cs && n < 10) begin cycle(); n++; end
      g = ncyc;
      n = 0;
      while (!a_ack && n < 40) begin cycle(); n++; end
      chk("to_ack_seen", 32'(a_ack), 1);
      chk("to_latency", 32'(ncyc - g), TO);
      chk("to_rdata", a_rdata, 32'hFFFFFFFF);
      chk("to_err", 32'(timeout_err), 1);
      repeat (5) cycle();
      chk("to_err_sticky", 32'(timeout_err), 1);
      reset = 1'b1; model_clear(); cycle();
      chk("to_err_reset", 32'(timeout_err), 0);
      reset = 1'b0; chk_on = 1;
`endif

      // randomized traffic against the model
      reset = 1'b1; model_clear(); cycle(); reset = 1'b0;
      rnd = 1; na = 0; nb = 0;
      for (int i = 0; i < 3000; i++) begin
         cycle();
         if (a_ack) na++;
         if (b_ack) nb++;
      end
      rnd = 0;
      chk("rnd_a_activity", 32'(na > 50), 1);
      chk("rnd_b_activity", 32'(nb > 50), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
